pipe_cla_adder: RTL
===================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the operand and sum width in bits (legal: 4..64, multiple of BLOCK).
REQ-002 The block SHALL take parameter BLOCK, default 4, as the carry-lookahead group size in bits (legal: 2, 4 or 8).
REQ-003 The block SHALL have port clk, input, 1 bit, as the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, as the asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port c_in, input, 1 bit: the carry-in for add mode.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result ports hold a valid result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-012 The block SHALL have port s, output, WIDTH bits: the sum or difference.
REQ-013 The block SHALL have ports c_out, ovf and zero, output, 1 bit each:
- c_out: carry out of the MSB;
- ovf: signed overflow;
- zero: s equals 0.

Function
REQ-014 The effective operation SHALL be:
- add: s = a + b + c_in;
- subtract: s = a + ~b + 1, with c_in ignored.
Results SHALL be taken modulo 2^WIDTH.
REQ-015 Carries SHALL use a two-level lookahead:
- per-bit g = a&b' and p = a^b', where b' is b or ~b;
- per-group G/P over BLOCK bits;
- group carries resolved by lookahead across groups.
No ripple chain across groups is permitted.
REQ-016 Pipeline stage 1 SHALL register g, p, the group G/P, the effective carry-in and the operand MSBs; stage 2 SHALL register s, c_out, ovf and zero.
REQ-017 An operand set SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-018 The result SHALL appear with out_valid=1 exactly 2 cycles after acceptance when there is no backpressure.
REQ-019 Stage 2 SHALL advance when out_valid is 0 or out_ready is 1; otherwise s, c_out, ovf and zero SHALL hold stable.
REQ-020 in_ready SHALL be 1 when stage 1 is empty or stage 1 can advance into stage 2 this cycle, and SHALL be combinationally independent of in_valid.
REQ-021 With in_valid and out_ready held high, the block SHALL sustain one result per cycle in acceptance order, with no drops or duplicates.
REQ-022 With out_ready held low, at most 2 operand sets SHALL be held, after which in_ready SHALL be 0.
REQ-023 A simultaneous accept and output handshake in the same cycle SHALL both take effect.
REQ-024 In subtract mode, c_out SHALL be 1 exactly when a >= b unsigned (no borrow).
REQ-025 ovf SHALL be 1 when the operand MSBs (a and b') are equal and differ from s[WIDTH-1].
REQ-026 Output data ports SHALL be don't-care while out_valid is 0; out_valid is the only qualifier.

Reset
REQ-027 While rst is 1, the block SHALL force out_valid=0, the stage-1 valid to 0, and s, c_out, ovf and zero to 0.
REQ-028 in_ready SHALL read 1 on the first cycle after rst is released.
REQ-029 An rst assertion mid-operation SHALL discard all in-flight operand sets, with no partial result emitted after release.

Configuration
REQ-030 When macro PIPE_CLA_SAT_EN is defined, a result with ovf=1 SHALL be clamped to the signed limit:
- 0x7FFF for WIDTH=16 when a[MSB] is 0;
- 0x8000 when a[MSB] is 1.
ovf SHALL still be reported as 1.
REQ-031 When PIPE_CLA_SAT_EN is undefined, s SHALL wrap modulo 2^WIDTH with no clamp logic present.

Verification (WIDTH=16, BLOCK=4)
REQ-032 Add a=0x1234, b=0x4321, c_in=1, out_ready=1 -> 2 cycles later: s=0x5556, c_out=0, ovf=0, zero=0.
REQ-033 Add a=0xFFFF, b=0x0001, c_in=0 -> s=0x0000, c_out=1, zero=1, ovf=0 (full-width carry propagation across all groups).
REQ-034 Add a=0x7FFF, b=0x0001 -> ovf=1 and:
- s=0x8000 without PIPE_CLA_SAT_EN;
- s=0x7FFF with PIPE_CLA_SAT_EN.
REQ-035 Sub a=0x0005, b=0x0007, c_in=1 -> s=0xFFFE, c_out=0, ovf=0 (c_in ignored).
REQ-036 Stream 8 back-to-back sets with out_ready low for 4 cycles mid-stream -> in_ready=0 after 2 sets are held, outputs stable while stalled, all 8 results delivered in order.
REQ-037 Assert rst with 2 sets in flight -> out_valid=0 immediately; no stale result after release; in_ready=1 on the next cycle.

Source files
------------

// File: rtl/pipe_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional saturation on signed overflow is enabled by defining PIPE_CLA_SAT_EN.
module pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / BLOCK;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g_d, p_d;
    logic [NG-1:0]    gg_d, gp_d;
    logic             cin_d;

    logic [WIDTH-1:0] g_q, p_q;
    logic [NG-1:0]    gg_q, gp_q;
    logic             cin_q, amsb_q, bmsb_q;
    logic             v1_q;

    logic [NG:0]      gc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_d;
    logic             c_d, ovf_d, zero_d;

    logic [WIDTH-1:0] s_q;
    logic             c_q, ovf_q, zero_q, ov_q;
    logic             adv2;

    assign adv2     = !ov_q || out_ready;
    assign in_ready = !v1_q || adv2;

    assign bx    = sub ? ~b : b;
    assign cin_d = sub ? 1'b1 : c_in;
    assign g_d   = a & bx;
    assign p_d   = a ^ bx;

    always_comb begin
        gg_d = '0;
        gp_d = '1;
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                gg_d[j] = g_d[j*BLOCK+i] | (p_d[j*BLOCK+i] & gg_d[j]);
                gp_d[j] = gp_d[j] & p_d[j*BLOCK+i];
            end
        end
    end

    // Each group carry is a flat sum of products over the group G/P terms.
    always_comb begin
        logic t;
        t     = 1'b0;
        gc    = '0;
        gc[0] = cin_q;
        for (int j = 1; j <= NG; j++) begin
            for (int k = 0; k < j; k++) begin
                t = gg_q[k];
                for (int m = k + 1; m < j; m++) t = t & gp_q[m];
                gc[j] = gc[j] | t;
            end
            t = cin_q;
            for (int m = 0; m < j; m++) t = t & gp_q[m];
            gc[j] = gc[j] | t;
        end
    end

    always_comb begin
        logic c;
        c   = 1'b0;
        sum = '0;
        for (int j = 0; j < NG; j++) begin
            c = gc[j];
            for (int i = 0; i < BLOCK; i++) begin
                sum[j*BLOCK+i] = p_q[j*BLOCK+i] ^ c;
                if (i < BLOCK - 1)
                    c = g_q[j*BLOCK+i] | (p_q[j*BLOCK+i] & c);
            end
        end
    end

    always_comb begin
        c_d   = gc[NG];
        ovf_d = (amsb_q == bmsb_q) && (sum[WIDTH-1] != amsb_q);
        s_d   = sum;
`ifdef PIPE_CLA_SAT_EN
        if (ovf_d)
            s_d = amsb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        zero_d = (s_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            g_q    <= '0;
            p_q    <= '0;
            gg_q   <= '0;
            gp_q   <= '0;
            cin_q  <= 1'b0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
        end else if (in_ready) begin
            v1_q <= in_valid;
            if (in_valid) begin
                g_q    <= g_d;
                p_q    <= p_d;
                gg_q   <= gg_d;
                gp_q   <= gp_d;
                cin_q  <= cin_d;
                amsb_q <= a[WIDTH-1];
                bmsb_q <= bx[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q   <= 1'b0;
            s_q    <= '0;
            c_q    <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv2) begin
            ov_q <= v1_q;
            if (v1_q) begin
                s_q    <= s_d;
                c_q    <= c_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = ov_q;
    assign s         = s_q;
    assign c_out     = c_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
